// File: rtl/wavetable_mixer.sv
// -----------------------------------------------------------------------------
// wavetable_mixer
//   Multi-voice wavetable sample player. NCH voices each walk a phase pointer
//   through a shared 2^AW-entry sample table at their own divided rate. Voices
//   play in loop or one-shot mode with a 4-bit volume. A single ROM port is
//   time-multiplexed across the voices, one voice per cycle. The scaled
//   samples are summed into one saturating unsigned mix word every NCH cycles.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   ena          global phase-advance enable (fetch/mix always run)
//   trig[NCH]    per-voice start/restart, level-sampled
//   stop[NCH]    per-voice stop, level-sampled (trig wins)
//   loop[NCH]    per-voice mode, 1=loop, 0=one-shot
//   div          per-voice rate divider, voice c at [c*DIVW +: DIVW]
//   vol          per-voice volume 0..15, voice c at [c*4 +: 4]
//   rom_addr     registered table address
//   rom_data     table word for rom_addr (combinational ROM)
//   sample_out   registered mixed sample
//   sample_valid one-cycle pulse when sample_out updates
//   active[NCH]  voice is playing
// -----------------------------------------------------------------------------
module wavetable_mixer #(
  parameter int NCH  = 4,
  parameter int AW   = 7,
  parameter int DW   = 8,
  parameter int OW   = 16,
  parameter int DIVW = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [NCH-1:0]      trig,
  input  logic [NCH-1:0]      stop,
  input  logic [NCH-1:0]      loop,
  input  logic [NCH*DIVW-1:0] div,
  input  logic [NCH*4-1:0]    vol,
  output logic [AW-1:0]       rom_addr,
  input  logic [DW-1:0]       rom_data,
  output logic [OW-1:0]       sample_out,
  output logic                sample_valid,
  output logic [NCH-1:0]      active
);

  localparam int TW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = DW + 4;
  localparam int SW = DW + 4 + $clog2(NCH);
  localparam logic [AW-1:0] PH_LAST  = '1;
  localparam logic [TW-1:0] SLOT_LAST = TW'(NCH - 1);

  typedef enum logic {
    S_IDLE,
    S_PLAY
  } state_t;

  state_t          r_state  [NCH];
  logic [AW-1:0]   r_phase  [NCH];
  logic [DIVW-1:0] r_divcnt [NCH];

  logic [TW-1:0]   r_slot;
  logic [TW-1:0]   r_tag;
  logic            r_tag_act;
  logic [SW-1:0]   r_acc;

  logic [DIVW-1:0] w_div [NCH];
  logic [3:0]      w_vol [NCH];
  logic [CW-1:0]   w_contrib;
  logic [SW-1:0]   w_sum;
  logic [OW-1:0]   w_sat;

  // Unpack the flat per-voice buses.
  always_comb begin
    for (int unsigned c = 0; c < NCH; c++) begin
      w_div[c] = div[c*DIVW +: DIVW];
      w_vol[c] = vol[c*4 +: 4];
    end
  end

  always_comb begin
    active = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      active[c] = (r_state[c] == S_PLAY);
    end
  end

  // ---------------------------------------------------------------------------
  // Per-voice phase FSMs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        r_state[c]  <= S_IDLE;
        r_phase[c]  <= '0;
        r_divcnt[c] <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if (trig[c]) begin
          r_state[c]  <= S_PLAY;
          r_phase[c]  <= '0;
          r_divcnt[c] <= '0;
        end else if (stop[c]) begin
          r_state[c]  <= S_IDLE;
          r_phase[c]  <= '0;
          r_divcnt[c] <= '0;
        end else if ((r_state[c] == S_PLAY) && ena) begin
          // >= rather than == so a divider lowered below the running count
          // still produces a step on the next enabled cycle.
          if (r_divcnt[c] >= w_div[c]) begin
            r_divcnt[c] <= '0;
            if (r_phase[c] == PH_LAST) begin
              r_phase[c] <= '0;
              if (!loop[c]) begin
                r_state[c] <= S_IDLE;
              end
            end else begin
              r_phase[c] <= r_phase[c] + AW'(1);
            end
          end else begin
            r_divcnt[c] <= r_divcnt[c] + DIVW'(1);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch / mix pipeline
  //   Stage 1 presents a voice's phase on rom_addr with its tag; stage 2 scales
  //   the returned word and accumulates. The last voice's stage-2 cycle folds
  //   its contribution straight into the output word and clears the
  //   accumulator, so there is no idle gap between mix frames.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_contrib = '0;
    if (r_tag_act) begin
      w_contrib = CW'(rom_data) * CW'(w_vol[r_tag]);
    end
    w_sum = r_acc + SW'(w_contrib);
  end

  generate
    if (SW > OW) begin : g_sat
      always_comb w_sat = (|w_sum[SW-1:OW]) ? '1 : w_sum[OW-1:0];
    end else begin : g_nosat
      always_comb w_sat = OW'(w_sum);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot       <= '0;
      r_tag        <= '0;
      r_tag_act    <= 1'b0;
      r_acc        <= '0;
      rom_addr     <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      rom_addr  <= r_phase[r_slot];
      r_tag     <= r_slot;
      r_tag_act <= (r_state[r_slot] == S_PLAY);
      r_slot    <= (r_slot == SLOT_LAST) ? '0 : r_slot + TW'(1);

      if (r_tag == SLOT_LAST) begin
        sample_out   <= w_sat;
        r_acc        <= '0;
        sample_valid <= 1'b1;
      end else begin
        r_acc        <= w_sum;
        sample_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wavetable_mixer.sv
// -----------------------------------------------------------------------------
// tb_wavetable_mixer
//   Self-checking bench for wavetable_mixer. Two instances share the stimulus:
//   the default 16-bit mix and a 12-bit mix that exercises saturation. A
//   behavioural model follows the voice rules and the mix timing, and one
//   compare process checks every output on every falling edge. Directed
//   scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_wavetable_mixer;

  localparam int NCH  = 4;
  localparam int AW   = 7;
  localparam int DW   = 8;
  localparam int DIVW = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ena;
  logic [NCH-1:0]    trig, stop, loop;
  logic [NCH*DIVW-1:0] div;
  logic [NCH*4-1:0]  vol;

  logic [AW-1:0]     rom_addr, rom_addr12;
  logic [DW-1:0]     rom_data, rom_data12;
  logic [15:0]       sample_out;
  logic [11:0]       sample_out12;
  logic              sample_valid, sample_valid12;
  logic [NCH-1:0]    active, active12;

  logic [DW-1:0]     rom [1<<AW];

  assign rom_data   = rom[rom_addr];
  assign rom_data12 = rom[rom_addr12];

  always #5 clk = ~clk;

  wavetable_mixer u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .trig(trig), .stop(stop), .loop(loop),
    .div(div), .vol(vol), .rom_addr(rom_addr), .rom_data(rom_data),
    .sample_out(sample_out), .sample_valid(sample_valid), .active(active)
  );

  wavetable_mixer #(.OW(12)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .trig(trig), .stop(stop), .loop(loop),
    .div(div), .vol(vol), .rom_addr(rom_addr12), .rom_data(rom_data12),
    .sample_out(sample_out12), .sample_valid(sample_valid12), .active(active12)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  int m_phase [NCH];
  int m_dc    [NCH];
  bit m_play  [NCH];
  int m_slot;
  bit f_have;
  int f_v, f_ph;
  bit f_act;
  int m_sum;
  int e_out, e_out12, e_addr;
  bit e_valid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        m_phase[c] = 0; m_dc[c] = 0; m_play[c] = 0;
      end
      m_slot = 0; f_have = 0; f_v = 0; f_ph = 0; f_act = 0;
      m_sum = 0; e_out = 0; e_out12 = 0; e_addr = 0; e_valid = 0;
    end else begin
      // Mix: the voice fetched on the previous edge is scaled by this edge.
      e_valid = 0;
      if (f_have) begin
        if (f_act) m_sum += int'(rom[f_ph]) * int'(vol[f_v*4 +: 4]);
        if (f_v == NCH-1) begin
          e_out   = m_sum;
          e_out12 = (m_sum > 4095) ? 4095 : m_sum;
          e_valid = 1;
          m_sum   = 0;
        end
      end
      // Fetch: round-robin snapshot of the voice state before this edge.
      f_have = 1;
      f_v    = m_slot;
      f_act  = m_play[m_slot];
      f_ph   = m_phase[m_slot];
      e_addr = f_ph;
      m_slot = (m_slot + 1) % NCH;
      // Voice rules.
      for (int c = 0; c < NCH; c++) begin
        if (trig[c]) begin
          m_play[c] = 1; m_phase[c] = 0; m_dc[c] = 0;
        end else if (stop[c]) begin
          m_play[c] = 0; m_phase[c] = 0; m_dc[c] = 0;
        end else if (m_play[c] && ena) begin
          if (m_dc[c] >= int'(div[c*DIVW +: DIVW])) begin
            m_dc[c] = 0;
            if (m_phase[c] == (1 << AW) - 1) begin
              m_phase[c] = 0;
              if (!loop[c]) m_play[c] = 0;
            end else begin
              m_phase[c] = m_phase[c] + 1;
            end
          end else begin
            m_dc[c] = m_dc[c] + 1;
          end
        end
      end
    end
  end

  // One compare process for every output, every cycle.
  always @(negedge clk) begin
    int ea;
    ea = 0;
    for (int c = 0; c < NCH; c++) ea |= int'(m_play[c]) << c;
    if (!rst_n) begin
      chk("rst_addr",   rom_addr, 0);
      chk("rst_out",    sample_out, 0);
      chk("rst_valid",  sample_valid, 0);
      chk("rst_active", active, 0);
    end else begin
      chk("addr",     rom_addr, e_addr);
      chk("valid",    sample_valid, e_valid);
      chk("active",   active, ea);
      chk("out",      sample_out, e_out);
      chk("addr12",   rom_addr12, e_addr);
      chk("valid12",  sample_valid12, e_valid);
      chk("active12", active12, ea);
      chk("out12",    sample_out12, e_out12);
    end
  end

  task automatic wait_valid();
    int n = 0;
    while (!sample_valid && n < 2*NCH) begin
      @(negedge clk);
      n++;
    end
    chk("valid_timeout", sample_valid, 1);
  endtask

  task automatic pulse_trig(input logic [NCH-1:0] t, input logic [NCH-1:0] s);
    @(negedge clk);
    trig = t; stop = s;
    @(negedge clk);
    trig = '0; stop = '0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int prev, maxv, nonmul, wraps, cnt, v0, nv, nc;

    rst_n = 1'b0; ena = 1'b0; trig = '0; stop = '0; loop = '0; div = '0; vol = '0;
    for (int i = 0; i < (1<<AW); i++) rom[i] = DW'(i);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("lit_reset_active", active, 0);
    chk("lit_reset_out", sample_out, 0);

    // Voice 0 loop, div=15, vol=15, ramp table.
    div[0*DIVW +: DIVW] = 8'd15;
    vol[0*4 +: 4] = 4'd15;
    loop[0] = 1'b1;
    ena = 1'b1;
    pulse_trig(4'b0001, 4'b0000);
    prev = -1; maxv = 0; nonmul = 0; wraps = 0;
    repeat (2100) begin
      @(negedge clk);
      if (sample_valid) begin
        if (sample_out % 15 != 0) nonmul++;
        if (int'(sample_out) > maxv) maxv = sample_out;
        if (int'(sample_out) < prev) wraps++;
        prev = sample_out;
      end
    end
    chk("lit_loop_max", maxv, 1905);
    chk("lit_loop_mult15", nonmul, 0);
    chk("lit_loop_wrapped", wraps, 1);
    chk("lit_loop_active", active[0], 1);

    // Voice 1 one-shot, div=0.
    pulse_trig(4'b0000, 4'b0001);
    div[1*DIVW +: DIVW] = 8'd0;
    vol[1*4 +: 4] = 4'd15;
    loop[1] = 1'b0;
    @(negedge clk);
    trig = 4'b0010;
    @(negedge clk);
    trig = '0;
    chk("lit_oneshot_start", active[1], 1);
    cnt = 0;
    while (active[1] && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    chk("lit_oneshot_len", cnt, 128);
    repeat (2*NCH+1) @(negedge clk);
    chk("lit_oneshot_silent", sample_out, 0);

    // Voice 2: trig+stop together, then retrigger from phase 50.
    div[2*DIVW +: DIVW] = 8'd0;
    vol[2*4 +: 4] = 4'd1;
    loop[2] = 1'b1;
    @(negedge clk);
    trig = 4'b0100; stop = 4'b0100;
    @(negedge clk);
    trig = '0; stop = '0;
    chk("lit_trig_beats_stop", active[2], 1);
    repeat (50) @(negedge clk);
    ena = 1'b0;
    repeat (2*NCH+1) @(negedge clk);
    wait_valid();
    chk("lit_phase50", sample_out, 50);
    pulse_trig(4'b0100, 4'b0000);
    repeat (2*NCH+2) @(negedge clk);
    wait_valid();
    chk("lit_retrig_phase0", sample_out, 0);
    chk("lit_retrig_active", active[2], 1);
    pulse_trig(4'b0000, 4'b0100);

    // Saturation: all voices full volume on 0xFF.
    for (int i = 0; i < (1<<AW); i++) rom[i] = 8'hFF;
    vol = 16'hFFFF;
    pulse_trig(4'b1111, 4'b0000);
    repeat (2*NCH+2) @(negedge clk);
    wait_valid();
    chk("lit_sum16", sample_out, 15300);
    chk("lit_sat12", sample_out12, 4095);
    pulse_trig(4'b0000, 4'b1111);
    vol = '0;
    for (int i = 0; i < (1<<AW); i++) rom[i] = DW'(i);

    // Freeze mid-play, including a divider cut below the running count.
    vol[0*4 +: 4] = 4'd15;
    div[0*DIVW +: DIVW] = 8'd15;
    loop[0] = 1'b1;
    ena = 1'b1;
    pulse_trig(4'b0001, 4'b0000);
    repeat (40) @(negedge clk);
    div[0*DIVW +: DIVW] = 8'd2;
    repeat (30) @(negedge clk);
    ena = 1'b0;
    repeat (2*NCH+2) @(negedge clk);
    wait_valid();
    v0 = sample_out;
    nv = 0; nc = 0;
    repeat (100) begin
      @(negedge clk);
      if (sample_valid) begin
        nv++;
        if (int'(sample_out) != v0) nc++;
      end
    end
    chk("lit_freeze_pulses", nv, 25);
    chk("lit_freeze_const", nc, 0);
    chk("lit_freeze_active", active[0], 1);

    // Asynchronous reset mid-play.
    ena = 1'b1;
    repeat (37) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("lit_async_addr", rom_addr, 0);
    chk("lit_async_out", sample_out, 0);
    chk("lit_async_active", active, 0);
    chk("lit_async_valid", sample_valid, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
